// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// exception causes and request classification helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'd2;

    function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            return funct3 > F3_SW;
        else
            return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    endfunction

    // Only meaningful for legal funct3: bits [1:0] give the access size.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the LSU: store byte-enable/data packing and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_load_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_load_data = {24'd0, w_byte};
            F3_LHU:  o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

    // Loads always fetch the whole word; lane selection happens on return.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        if (i_we) begin
            case (i_funct3)
                F3_SB: begin
                    o_be    = 4'b0001 << i_offset;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_SH: begin
                    o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
            endcase
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time, runs a req/ack bus
// transaction with timeout, and writes load results back to the register file.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        wr_en_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        busy_o,
    output logic        exc_o,
    output logic [1:0]  exc_cause_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    logic               r_ready;
    logic               r_bus_req;
    logic               r_we;
    logic [2:0]         r_funct3;
    logic [1:0]         r_offset;
    logic [31:0]        r_bus_addr;
    logic [31:0]        r_wdata;
    logic [4:0]         r_rd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wr_en;
    logic [4:0]         r_rd_addr;
    logic [31:0]        r_rd_data;
    logic               r_exc;
    logic [1:0]         r_cause;

    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_load;
    logic               w_illegal;
    logic               w_misaligned;

    assign w_illegal    = lsu_illegal(req_we_i, req_funct3_i);
    assign w_misaligned = lsu_misaligned(req_funct3_i, req_addr_i[1:0]);

    lsu_align u_align (
        .i_we        (r_we),
        .i_funct3    (r_funct3),
        .i_offset    (r_offset),
        .i_wdata     (r_wdata),
        .i_rdata     (bus_rdata_i),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b0;
            r_bus_req  <= 1'b0;
            r_we       <= 1'b0;
            r_funct3   <= 3'd0;
            r_offset   <= 2'd0;
            r_bus_addr <= 32'd0;
            r_wdata    <= 32'd0;
            r_rd       <= 5'd0;
            r_cnt      <= '0;
            r_wr_en    <= 1'b0;
            r_rd_addr  <= 5'd0;
            r_rd_data  <= 32'd0;
            r_exc      <= 1'b0;
            r_cause    <= 2'd0;
        end else begin
            r_wr_en <= 1'b0;
            r_exc   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (req_valid_i && r_ready) begin
                        r_we       <= req_we_i;
                        r_funct3   <= req_funct3_i;
                        r_offset   <= req_addr_i[1:0];
                        r_bus_addr <= {req_addr_i[31:2], 2'b00};
                        r_wdata    <= req_wdata_i;
                        r_rd       <= req_rd_i;
                        if (w_illegal) begin
                            r_exc   <= 1'b1;
                            r_cause <= CAUSE_ILLEGAL;
                        end else if (w_misaligned) begin
                            r_exc   <= 1'b1;
                            r_cause <= CAUSE_MISALIGNED;
                        end else begin
                            r_state   <= ST_BUS;
                            r_bus_req <= 1'b1;
                            r_ready   <= 1'b0;
                            r_cnt     <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_ack_i) begin
                        r_bus_req <= 1'b0;
                        if (r_we) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state   <= ST_WB;
                            r_rd_data <= w_load;
                            r_rd_addr <= r_rd;
                            r_wr_en   <= (r_rd != 5'd0);
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        // Abort: drop the request and report instead of writing back.
                        r_bus_req <= 1'b0;
                        r_state   <= ST_IDLE;
                        r_ready   <= 1'b1;
                        r_exc     <= 1'b1;
                        r_cause   <= CAUSE_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ready   <= 1'b1;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = r_ready;
    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_req & r_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_be_o    = r_bus_req ? w_be : 4'b0000;
    assign bus_wdata_o = r_bus_req ? w_wdata : 32'd0;
    assign wr_en_o     = r_wr_en;
    assign rd_addr_o   = r_rd_addr;
    assign rd_data_o   = r_rd_data;
    assign busy_o      = (r_state != ST_IDLE);
    assign exc_o       = r_exc;
    assign exc_cause_o = r_cause;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu (TIMEOUT=4): loads, stores,
// exceptions, timeout, rd=0 writeback suppression and mid-transaction reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        wr_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        busy_o;
    logic        exc_o;
    logic [1:0]  exc_cause_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_rd_i     (req_rd_i),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i),
        .wr_en_o      (wr_en_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .busy_o       (busy_o),
        .exc_o        (exc_o),
        .exc_cause_o  (exc_cause_o)
    );

    // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; on return we are in cycle 1.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_rd_i     = rd;
        tick();
        req_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({req_ready_o, bus_req_o, wr_en_o, exc_o, busy_o} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready/req/wr/exc/busy=%b required 00000",
                     {req_ready_o, bus_req_o, wr_en_o, exc_o, busy_o});
        end
        n_checks++;
        if ({bus_addr_o, rd_data_o, bus_be_o} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h rd_data=%h be=%b required zeros",
                     bus_addr_o, rd_data_o, bus_be_o);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: got %b required 1", req_ready_o);
        end
        $display("txn reset done");
    endtask

    task automatic test_loads();
        logic [2:0]  t_f3   [8] = '{3'd2, 3'd0, 3'd4, 3'd5, 3'd1, 3'd1, 3'd0, 3'd4};
        logic [31:0] t_addr [8] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
        logic [31:0] t_rdat [8] = '{32'hDEADBEEF, 32'h80123456, 32'h80123456, 32'h80123456,
                                    32'h80123456, 32'h1234F00D, 32'h1234F00D, 32'h1234F00D};
        logic [31:0] t_exp  [8] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h00008012,
                                    32'hFFFF8012, 32'hFFFFF00D, 32'hFFFFFFF0, 32'h0000000D};
        int          t_ack  [8] = '{2, 1, 1, 3, 1, 2, 1, 1};
        for (int i = 0; i < 8; i++) begin
            logic [4:0] rd;
            rd = 5'(i + 5);
            issue(1'b0, t_f3[i], t_addr[i], 32'h0, rd);
            n_checks++;
            if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 || bus_be_o !== 4'b1111 ||
                bus_addr_o !== {t_addr[i][31:2], 2'b00} || req_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL load%0d_bus: got req=%b we=%b be=%b addr=%h ready=%b required 1 0 1111 %h 0",
                         i, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, req_ready_o,
                         {t_addr[i][31:2], 2'b00});
            end
            for (int c = 1; c < t_ack[i]; c++) tick();
            n_checks++;
            if (bus_req_o !== 1'b1 || wr_en_o !== 1'b0) begin
                n_fail++;
                $display("FAIL load%0d_hold: got req=%b wr_en=%b required 1 0", i, bus_req_o, wr_en_o);
            end
            bus_ack_i   = 1'b1;
            bus_rdata_i = t_rdat[i];
            tick();
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'h0;
            n_checks++;
            if (wr_en_o !== 1'b1 || rd_addr_o !== rd || rd_data_o !== t_exp[i] || bus_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL load%0d_wb: got wr=%b rd=%0d data=%h req=%b required 1 %0d %h 0",
                         i, wr_en_o, rd_addr_o, rd_data_o, bus_req_o, rd, t_exp[i]);
            end
            n_checks++;
            if (req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL load%0d_wb_state: got ready=%b busy=%b required 0 1", i, req_ready_o, busy_o);
            end
            tick();
            n_checks++;
            if (wr_en_o !== 1'b0 || req_ready_o !== 1'b1 || rd_data_o !== t_exp[i]) begin
                n_fail++;
                $display("FAIL load%0d_done: got wr=%b ready=%b data=%h required 0 1 %h",
                         i, wr_en_o, req_ready_o, rd_data_o, t_exp[i]);
            end
            $display("txn load f3=%0d addr=%h rdata=%h rd=%0d -> %h", t_f3[i], t_addr[i], t_rdat[i], rd, rd_data_o);
        end
    endtask

    task automatic test_stores();
        logic [2:0]  t_f3   [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
        logic [31:0] t_addr [4] = '{32'h201, 32'h202, 32'h204, 32'h3FF};
        logic [31:0] t_wd   [4] = '{32'h000000AB, 32'h1234CDEF, 32'h01234567, 32'h55AA0011};
        logic [3:0]  t_be   [4] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000};
        logic [31:0] t_bw   [4] = '{32'hABABABAB, 32'hCDEFCDEF, 32'h01234567, 32'h11111111};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, t_f3[i], t_addr[i], t_wd[i], 5'd3);
            n_checks++;
            if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_be_o !== t_be[i] ||
                bus_wdata_o !== t_bw[i] || bus_addr_o !== {t_addr[i][31:2], 2'b00}) begin
                n_fail++;
                $display("FAIL store%0d_bus: got req=%b we=%b be=%b wdata=%h addr=%h required 1 1 %b %h %h",
                         i, bus_req_o, bus_we_o, bus_be_o, bus_wdata_o, bus_addr_o,
                         t_be[i], t_bw[i], {t_addr[i][31:2], 2'b00});
            end
            bus_ack_i = 1'b1;
            tick();
            bus_ack_i = 1'b0;
            n_checks++;
            if (req_ready_o !== 1'b1 || bus_req_o !== 1'b0 || wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL store%0d_done: got ready=%b req=%b wr=%b busy=%b required 1 0 0 0",
                         i, req_ready_o, bus_req_o, wr_en_o, busy_o);
            end
            $display("txn store f3=%0d addr=%h wdata=%h be=%b", t_f3[i], t_addr[i], t_wd[i], t_be[i]);
        end
    endtask

    task automatic test_exceptions();
        logic        t_we   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  t_f3   [5] = '{3'd2, 3'd3, 3'd3, 3'd1, 3'd5};
        logic [31:0] t_addr [5] = '{32'h102, 32'h100, 32'h100, 32'h201, 32'h103};
        logic [1:0]  t_cause[5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 5; i++) begin
            issue(t_we[i], t_f3[i], t_addr[i], 32'h12345678, 5'd4);
            n_checks++;
            if (exc_o !== 1'b1 || exc_cause_o !== t_cause[i] || bus_req_o !== 1'b0 || req_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL exc%0d_pulse: got exc=%b cause=%0d req=%b ready=%b required 1 %0d 0 1",
                         i, exc_o, exc_cause_o, bus_req_o, req_ready_o, t_cause[i]);
            end
            tick();
            n_checks++;
            if (exc_o !== 1'b0 || bus_req_o !== 1'b0 || wr_en_o !== 1'b0) begin
                n_fail++;
                $display("FAIL exc%0d_after: got exc=%b req=%b wr=%b required 0 0 0", i, exc_o, bus_req_o, wr_en_o);
            end
            $display("txn exception we=%b f3=%0d addr=%h cause=%0d", t_we[i], t_f3[i], t_addr[i], t_cause[i]);
        end
    endtask

    task automatic test_timeout();
        issue(1'b0, 3'd2, 32'h300, 32'h0, 5'd7);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (bus_req_o !== 1'b1 || exc_o !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: got req=%b exc=%b required 1 0", c, bus_req_o, exc_o);
            end
            tick();
        end
        n_checks++;
        if (exc_o !== 1'b1 || exc_cause_o !== 2'd2 || bus_req_o !== 1'b0 || wr_en_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_exc: got exc=%b cause=%0d req=%b wr=%b ready=%b required 1 2 0 0 1",
                     exc_o, exc_cause_o, bus_req_o, wr_en_o, req_ready_o);
        end
        tick();
        n_checks++;
        if (exc_o !== 1'b0 || wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_after: got exc=%b wr=%b busy=%b required 0 0 0", exc_o, wr_en_o, busy_o);
        end
        $display("txn timeout load addr=00000300");
    endtask

    task automatic test_rd_zero();
        issue(1'b0, 3'd2, 32'h400, 32'h0, 5'd0);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hCAFEF00D;
        tick();
        bus_ack_i   = 1'b0;
        n_checks++;
        if (wr_en_o !== 1'b0 || busy_o !== 1'b1 || req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rd0_wb: got wr=%b busy=%b ready=%b required 0 1 0", wr_en_o, busy_o, req_ready_o);
        end
        tick();
        n_checks++;
        if (wr_en_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rd0_done: got wr=%b ready=%b required 0 1", wr_en_o, req_ready_o);
        end
        $display("txn load rd=0 addr=00000400 (no writeback)");
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'd2, 32'h500, 32'h0, 5'd9);
        n_checks++;
        if (bus_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_req: got %b required 1", bus_req_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus_req_o !== 1'b0 || wr_en_o !== 1'b0 || exc_o !== 1'b0 || req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_reset: got req=%b wr=%b exc=%b ready=%b required 0 0 0 0",
                     bus_req_o, wr_en_o, exc_o, req_ready_o);
        end
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h11223344;
        tick();
        bus_ack_i   = 1'b0;
        n_checks++;
        if (wr_en_o !== 1'b0 || req_ready_o !== 1'b1 || bus_req_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_late_ack: got wr=%b ready=%b req=%b busy=%b required 0 1 0 0",
                     wr_en_o, req_ready_o, bus_req_o, busy_o);
        end
        tick();
        n_checks++;
        if (wr_en_o !== 1'b0 || exc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got wr=%b exc=%b required 0 0", wr_en_o, exc_o);
        end
        $display("txn reset during bus transaction");
    endtask

    initial begin
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'd0;
        req_addr_i   = 32'd0;
        req_wdata_i  = 32'd0;
        req_rd_i     = 5'd0;
        bus_ack_i    = 1'b0;
        bus_rdata_i  = 32'd0;
        test_reset();
        test_loads();
        test_stores();
        test_exceptions();
        test_timeout();
        test_rd_zero();
        test_reset_mid();
        test_loads();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-issue RISC-V core. It accepts one memory instruction at a time from the execute stage and runs a request/acknowledge transaction on the data bus. Store data and byte enables are packed, load data is extracted and sign/zero-extended, and each load result goes to the register file write port (wr_en / rd_addr / rd_data) as a one-cycle pulse. It also reports misaligned accesses, illegal funct3 codes and bus timeouts.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles bus_req_o stays high without bus_ack_i before the access is aborted.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  execute stage presents a memory op
- req_ready_o  out  1  LSU can accept (IDLE only)
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr_i  in  32  effective byte address
- req_wdata_i  in  32  store source (rs2 value)
- req_rd_i  in  5  load destination register
- bus_req_o  out  1  bus transaction active
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  word address, {addr[31:2],2'b00}
- bus_be_o  out  4  byte enables (stores; 4'b1111 for loads)
- bus_wdata_o  out  32  packed store data
- bus_ack_i  in  1  transaction complete; rdata valid same cycle
- bus_rdata_i  in  32  read word
- wr_en_o  out  1  register file write strobe
- rd_addr_o  out  5  register file destination
- rd_data_o  out  32  extended load result
- busy_o  out  1  state != IDLE
- exc_o  out  1  one-cycle exception pulse
- exc_cause_o  out  2  0 misaligned, 1 illegal funct3, 2 bus timeout; valid with exc_o

## Operation
- States: IDLE, BUS, WB.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o: capture all req fields.
  - Illegal funct3: loads 3/6/7, stores >2. Gives exc_o, cause 1, next cycle; stay IDLE.
  - Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0. Gives exc_o, cause 0, next cycle; stay IDLE.
  - Else go to BUS.
- BUS:
  - bus_* driven from registers, held stable until ack.
  - bus_ack_i sampled only while bus_req_o=1.
  - On ack: store goes to IDLE. Load captures the extracted value and goes to WB.
  - The timeout counter clears on entry and increments each BUS cycle. At count == TIMEOUT-1 without ack: exc_o, cause 2, next cycle; go to IDLE; no writeback.
- WB:
  - wr_en_o=1 for exactly one cycle, then IDLE.
  - rd==0 keeps wr_en_o=0; the FSM still passes through WB.
- Store packing:
  - SB: be=4'b0001<<addr[1:0], wdata={4{b}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{h}}.
  - SW: be=4'b1111.
- Load extraction: select the byte/half by addr[1:0] from bus_rdata_i. LB/LH sign-extend; LBU/LHU zero-extend.
- Reset values: all outputs 0 except req_ready_o (0 during the reset cycle, 1 after); state IDLE; counter 0.
- Reset mid-operation: bus_req_o=0 at the next edge, transaction discarded, no wr_en_o or exc_o. An ack arriving after reset is ignored.

## Timing
- Handshake edge = cycle 0. bus_req_o goes high in cycle 1.
- Ack in cycle k (k≥1) gives wr_en_o high in cycle k+1 and req_ready_o high in cycle k+2. Minimum load occupancy is 3 cycles.
- Store ack in cycle k gives req_ready_o high in cycle k+1.
- Exception pulse in cycle 1 for misaligned or illegal requests; req_ready_o stays 1 throughout.
- Timeout: exc_o in cycle TIMEOUT+1 if ack never arrives.
- wr_en_o/rd_addr_o/rd_data_o are registered; rd_data_o holds its last value when wr_en_o=0.

## Structure
- Shared package (lsu_pkg): funct3 localparams (F3_LB…F3_SW), state encoding, exception cause codes.
- One sub-module, lsu_align: purely combinational. Store packing (be/wdata) and load extraction/extension. Instantiated once; the FSM and counter stay in lsu.

## Test plan
- LW addr 0x100, bus_rdata 0xDEADBEEF, ack after 2 cycles -> bus_addr 0x100, be 4'b1111, wr_en_o pulse with rd=5, rd_data 0xDEADBEEF.
- LB addr 0x103, rdata 0x80123456 -> rd_data 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x00008012.
- SB addr 0x201, wdata 0x000000AB -> be 4'b0010, bus_wdata 0xABABABAB, bus_we 1, no wr_en_o.
- LW addr 0x102 -> exc_o, cause 0, next cycle, no bus_req_o. Load funct3=3 -> cause 1.
- Load with no ack, TIMEOUT=4 -> exc_o, cause 2, after 4 BUS cycles, back to IDLE. Load rd=0 with ack -> no wr_en_o.
- rst asserted during BUS -> bus_req_o=0 next cycle. Ack the cycle after -> no wr_en_o, req_ready_o=1.
